// File: rtl/mem_rr_arbiter_if.sv
// Native picorv32-style valid/ready memory port bundle.
// Requesters drive the master side; the arbiter and memories sit on the slave side.
interface mem_rr_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic                  valid;
   logic                  instr;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  ready;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output valid, instr, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, instr, addr, wdata, wstrb,
      output ready, rdata
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one native mem port between two requesters, one
// transaction in flight. Define MEM_TIMEOUT_EN to add a request-timeout watchdog.
module mem_rr_arbiter #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       TIMEOUT   = 16,
   parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   mem_rr_arbiter_if.slave         m0,
   mem_rr_arbiter_if.slave         m1,
   mem_rr_arbiter_if.master        s,
   output logic [1:0]              grant,
   output logic                    timeout_err
);
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Requester-side signals gathered into indexable arrays
   logic [1:0]        req_valid;
   logic [1:0]        req_instr;
   logic [ADDR_W-1:0] req_addr  [2];
   logic [DATA_W-1:0] req_wdata [2];
   logic [STRB_W-1:0] req_wstrb [2];

   assign req_valid    = {m1.valid, m0.valid};
   assign req_instr    = {m1.instr, m0.instr};
   assign req_addr[0]  = m0.addr;
   assign req_addr[1]  = m1.addr;
   assign req_wdata[0] = m0.wdata;
   assign req_wdata[1] = m1.wdata;
   assign req_wstrb[0] = m0.wstrb;
   assign req_wstrb[1] = m1.wstrb;

   state_t            state_reg,      state_next;
   logic              s_valid_reg,    s_valid_next;
   logic              s_instr_reg,    s_instr_next;
   logic [ADDR_W-1:0] s_addr_reg,     s_addr_next;
   logic [DATA_W-1:0] s_wdata_reg,    s_wdata_next;
   logic [STRB_W-1:0] s_wstrb_reg,    s_wstrb_next;
   logic [1:0]        grant_reg,      grant_next;
   logic              last_grant_reg, last_grant_next;
   logic              owner_reg,      owner_next;
   logic [1:0]        ready_reg,      ready_next;
   logic [DATA_W-1:0] rdata_reg  [2];
   logic [DATA_W-1:0] rdata_next [2];

   logic              resp_load;
   logic [DATA_W-1:0] resp_data;
   logic              win_idx;
   logic [1:0]        win_onehot;

   // Tie goes to whoever was not served last; a lone requester always wins
   always_comb begin
      win_idx = 1'b0;
      if (&req_valid) begin
         win_idx = ~last_grant_reg;
      end else if (req_valid[1]) begin
         win_idx = 1'b1;
      end
      win_onehot = win_idx ? 2'b10 : 2'b01;
   end

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic             timeout_err_reg, timeout_err_next;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tmo_cnt_reg     <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         tmo_cnt_reg     <= tmo_cnt_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   assign timeout_err = timeout_err_reg;
`else
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_next      = state_reg;
      s_valid_next    = s_valid_reg;
      s_instr_next    = s_instr_reg;
      s_addr_next     = s_addr_reg;
      s_wdata_next    = s_wdata_reg;
      s_wstrb_next    = s_wstrb_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      owner_next      = owner_reg;
      resp_load       = 1'b0;
      resp_data       = s.rdata;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_next     = tmo_cnt_reg;
      timeout_err_next = 1'b0;
`endif

      case (state_reg)
         ST_IDLE: begin
            if (|req_valid) begin
               s_valid_next    = 1'b1;
               s_instr_next    = req_instr[win_idx];
               s_addr_next     = req_addr[win_idx];
               s_wdata_next    = req_wdata[win_idx];
               s_wstrb_next    = req_wstrb[win_idx];
               grant_next      = win_onehot;
               last_grant_next = win_idx;
               owner_next      = win_idx;
               state_next      = ST_REQ;
`ifdef MEM_TIMEOUT_EN
               tmo_cnt_next    = '0;
`endif
            end
         end

         ST_REQ: begin
            // A ready arriving on the expiry cycle still completes normally
            if (s.ready) begin
               s_valid_next = 1'b0;
               resp_load    = 1'b1;
               state_next   = ST_RESP;
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo_cnt_reg == TMO_LAST) begin
               s_valid_next     = 1'b0;
               resp_load        = 1'b1;
               resp_data        = ERR_RDATA;
               timeout_err_next = 1'b1;
               state_next       = ST_RESP;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
            end
`endif
         end

         ST_RESP: begin
            grant_next = 2'b00;
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Only the owner sees the response; the other requester keeps its last rdata
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_resp
         logic hit;
         assign hit            = resp_load && (owner_reg == 1'(gi));
         assign ready_next[gi] = hit;
         assign rdata_next[gi] = hit ? resp_data : rdata_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg      <= ST_IDLE;
         s_valid_reg    <= 1'b0;
         s_instr_reg    <= 1'b0;
         s_addr_reg     <= '0;
         s_wdata_reg    <= '0;
         s_wstrb_reg    <= '0;
         grant_reg      <= 2'b00;
         last_grant_reg <= 1'b1;
         owner_reg      <= 1'b0;
         ready_reg      <= 2'b00;
         rdata_reg[0]   <= '0;
         rdata_reg[1]   <= '0;
      end else begin
         state_reg      <= state_next;
         s_valid_reg    <= s_valid_next;
         s_instr_reg    <= s_instr_next;
         s_addr_reg     <= s_addr_next;
         s_wdata_reg    <= s_wdata_next;
         s_wstrb_reg    <= s_wstrb_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         owner_reg      <= owner_next;
         ready_reg      <= ready_next;
         rdata_reg[0]   <= rdata_next[0];
         rdata_reg[1]   <= rdata_next[1];
      end
   end

   assign s.valid  = s_valid_reg;
   assign s.instr  = s_instr_reg;
   assign s.addr   = s_addr_reg;
   assign s.wdata  = s_wdata_reg;
   assign s.wstrb  = s_wstrb_reg;
   assign m0.ready = ready_reg[0];
   assign m0.rdata = rdata_reg[0];
   assign m1.ready = ready_reg[1];
   assign m1.rdata = rdata_reg[1];
   assign grant    = grant_reg;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: two requester drivers, a RAM responder,
// and a completion monitor; expected responses are queued per requester at issue.
`timescale 1ns/1ps
module tb_mem_rr_arbiter;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   typedef struct {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      int          issue_cyc;
   } exp_t;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic [1:0]  grant;
      logic        terr;
      int          cyc;
      logic        both;
   } obs_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] grant;
   logic       timeout_err;

   always #5 clk = ~clk;

   mem_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
   mem_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
   mem_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

   mem_rr_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERR_RDATA(32'hDEADBEEF)
   ) dut (
      .clk(clk), .resetn(resetn), .m0(m0_if), .m1(m1_if), .s(s_if),
      .grant(grant), .timeout_err(timeout_err)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   txn_t        cmd_q [2][$];
   exp_t        exp_q [2][$];
   obs_t        obs_q [$];
   logic [31:0] ram    [64];
   logic [31:0] shadow [64];
   logic        ram_en = 1'b1;
   int          ram_lat = 0;
   logic [31:0] last_s_addr = '0;
   logic [3:0]  last_s_wstrb = '0;
   logic        drv_flush = 1'b0;
   int          terr_cycles = 0;

   function automatic logic [31:0] init_word(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Shared requester step: retire on ready, then launch next queued command
   task automatic drv_next(input int id, input logic rdy, inout logic busy, inout txn_t t);
      exp_t e;
      int   idx;
      if (drv_flush) begin
         busy = 1'b0;
         cmd_q[id].delete();
      end else begin
         if (busy && rdy) busy = 1'b0;
         if (!busy && cmd_q[id].size() > 0) begin
            t = cmd_q[id].pop_front();
            idx = int'(t.addr[7:2]);
            e.rdata = shadow[idx];
            e.issue_cyc = cyc;
            for (int b = 0; b < 4; b++)
               if (t.wstrb[b]) shadow[idx][8*b +: 8] = t.wdata[8*b +: 8];
            exp_q[id].push_back(e);
            busy = 1'b1;
         end
      end
   endtask

   initial begin : drv0
      txn_t t = '{1'b0, 32'h0, 32'h0, 4'h0};
      logic busy = 1'b0;
      m0_if.valid = 1'b0; m0_if.instr = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
      forever begin
         @(negedge clk);
         drv_next(0, m0_if.ready, busy, t);
         m0_if.valid = busy; m0_if.instr = t.instr; m0_if.addr = t.addr;
         m0_if.wdata = t.wdata; m0_if.wstrb = t.wstrb;
      end
   end

   initial begin : drv1
      txn_t t = '{1'b0, 32'h0, 32'h0, 4'h0};
      logic busy = 1'b0;
      m1_if.valid = 1'b0; m1_if.instr = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
      forever begin
         @(negedge clk);
         drv_next(1, m1_if.ready, busy, t);
         m1_if.valid = busy; m1_if.instr = t.instr; m1_if.addr = t.addr;
         m1_if.wdata = t.wdata; m1_if.wstrb = t.wstrb;
      end
   end

   // RAM responder: ready after ram_lat waiting cycles, reads return pre-write data
   initial begin : ram_model
      int wait_cnt = 0;
      int idx;
      for (int i = 0; i < 64; i++) begin
         ram[i] = init_word(i);
         shadow[i] = init_word(i);
      end
      s_if.ready = 1'b0;
      s_if.rdata = '0;
      forever begin
         @(negedge clk);
         if (s_if.valid && !s_if.ready && ram_en) begin
            if (wait_cnt >= ram_lat) begin
               idx = int'(s_if.addr[7:2]);
               s_if.rdata = ram[idx];
               s_if.ready = 1'b1;
               last_s_addr = s_if.addr;
               last_s_wstrb = s_if.wstrb;
               for (int b = 0; b < 4; b++)
                  if (s_if.wstrb[b]) ram[idx][8*b +: 8] = s_if.wdata[8*b +: 8];
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            s_if.ready = 1'b0;
            if (!s_if.valid) wait_cnt = 0;
         end
      end
   end

   initial begin : monitor
      obs_t o;
      forever begin
         @(negedge clk);
         if (timeout_err) terr_cycles++;
         if (m0_if.ready || m1_if.ready) begin
            o.id    = m1_if.ready ? 1 : 0;
            o.rdata = m1_if.ready ? m1_if.rdata : m0_if.rdata;
            o.grant = grant;
            o.terr  = timeout_err;
            o.cyc   = cyc;
            o.both  = m0_if.ready && m1_if.ready;
            obs_q.push_back(o);
         end
      end
   end

   task automatic wait_obs(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (s_if.valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %b want 0", s_if.valid); end
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
      checks++;
      if ({m1_if.ready, m0_if.ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {m1_if.ready, m0_if.ready}); end
      checks++;
      if (m0_if.rdata !== 32'h0) begin errors++; $display("FAIL reset_m0_rdata got %h want 0", m0_if.rdata); end
      checks++;
      if (s_if.addr !== 32'h0) begin errors++; $display("FAIL reset_s_addr got %h want 0", s_if.addr); end
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
      resetn = 1'b1;
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_single_read();
      bit   ok;
      obs_t o;
      exp_t e;
      ram_lat = 1;
      @(posedge clk);
      cmd_q[0].push_back('{1'b0, 32'h10, 32'h0, 4'h0});
      wait_obs(1, 50, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_read_timeout got no ready want ready"); return; end
      o = obs_q.pop_front();
      e = exp_q[0].pop_front();
      checks++;
      if (o.id !== 0 || o.both !== 1'b0) begin errors++; $display("FAIL single_read_id got %0d both %b want 0 0", o.id, o.both); end
      checks++;
      if (o.rdata !== init_word(4)) begin errors++; $display("FAIL single_read_rdata got %h want %h", o.rdata, init_word(4)); end
      checks++;
      if (o.cyc - e.issue_cyc !== 3) begin errors++; $display("FAIL single_read_latency got %0d want 3", o.cyc - e.issue_cyc); end
      checks++;
      if (last_s_addr !== 32'h10) begin errors++; $display("FAIL single_read_s_addr got %h want 10", last_s_addr); end
      checks++;
      if (o.grant !== 2'b01) begin errors++; $display("FAIL single_read_grant got %b want 01", o.grant); end
      $display("txn m0 read addr=10 rdata=%h latency=%0d", o.rdata, o.cyc - e.issue_cyc);
   endtask

   // Fresh reset then simultaneous requests: m0 first, m1 second
   task automatic test_tie();
      bit   ok;
      obs_t o;
      exp_t e;
      apply_reset();
      ram_lat = 0;
      @(posedge clk);
      cmd_q[0].push_back('{1'b0, 32'h40, 32'h0, 4'h0});
      cmd_q[1].push_back('{1'b1, 32'h80, 32'h0, 4'h0});
      wait_obs(2, 60, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL tie_timeout got %0d responses want 2", obs_q.size()); return; end
      for (int k = 0; k < 2; k++) begin
         o = obs_q.pop_front();
         checks++;
         if (o.id !== k) begin errors++; $display("FAIL tie_order got %0d want %0d", o.id, k); end
         checks++;
         if (o.grant !== (k == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie_grant got %b want %b", o.grant, (k == 0 ? 2'b01 : 2'b10)); end
         if (exp_q[o.id].size() > 0) begin
            e = exp_q[o.id].pop_front();
            checks++;
            if (o.rdata !== e.rdata) begin errors++; $display("FAIL tie_rdata got %h want %h", o.rdata, e.rdata); end
         end
         $display("txn tie m%0d grant=%b rdata=%h", o.id, o.grant, o.rdata);
      end
   endtask

   task automatic test_round_robin();
      bit   ok;
      obs_t o;
      exp_t e;
      ram_lat = 0;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         cmd_q[0].push_back('{1'b0, 32'(4 * k), 32'h0, 4'h0});
         cmd_q[1].push_back('{1'b0, 32'(32'hC0 + 4 * k), 32'h0, 4'h0});
      end
      wait_obs(6, 150, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_timeout got %0d responses want 6", obs_q.size()); return; end
      for (int k = 0; k < 6; k++) begin
         o = obs_q.pop_front();
         checks++;
         if (o.id !== (k % 2)) begin errors++; $display("FAIL rr_order[%0d] got m%0d want m%0d", k, o.id, k % 2); end
         if (exp_q[o.id].size() > 0) begin
            e = exp_q[o.id].pop_front();
            checks++;
            if (o.rdata !== e.rdata) begin errors++; $display("FAIL rr_rdata[%0d] got %h want %h", k, o.rdata, e.rdata); end
         end
         $display("txn rr %0d m%0d grant=%b rdata=%h", k, o.id, o.grant, o.rdata);
      end
   endtask

   task automatic test_write();
      bit          ok;
      obs_t        o;
      exp_t        e;
      logic [31:0] want;
      ram_lat = 1;
      @(posedge clk);
      cmd_q[1].push_back('{1'b0, 32'h20, 32'hA5A5A5A5, 4'b0011});
      wait_obs(1, 50, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL write_timeout got no ready want ready"); return; end
      o = obs_q.pop_front();
      e = exp_q[1].pop_front();
      checks++;
      if (last_s_wstrb !== 4'b0011) begin errors++; $display("FAIL write_s_wstrb got %b want 0011", last_s_wstrb); end
      checks++;
      if (o.id !== 1 || o.rdata !== e.rdata) begin errors++; $display("FAIL write_resp got m%0d %h want m1 %h", o.id, o.rdata, e.rdata); end
      $display("txn m1 write addr=20 wstrb=%b", last_s_wstrb);
      cmd_q[1].push_back('{1'b0, 32'h20, 32'h0, 4'h0});
      wait_obs(1, 50, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL write_readback_timeout got no ready want ready"); return; end
      o = obs_q.pop_front();
      e = exp_q[1].pop_front();
      want = {init_word(8) >> 16, 16'hA5A5};
      checks++;
      if (o.rdata !== want) begin errors++; $display("FAIL write_readback got %h want %h", o.rdata, want); end
      $display("txn m1 read addr=20 rdata=%h", o.rdata);
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      ram_en = 1'b0;
      @(posedge clk);
      cmd_q[0].push_back('{1'b0, 32'h30, 32'h0, 4'h0});
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (s_if.valid) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL reset_mid_no_req got s_valid 0 want 1"); end
      drv_flush = 1'b1;
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      checks++;
      if (s_if.valid !== 1'b0) begin errors++; $display("FAIL reset_mid_s_valid got %b want 0", s_if.valid); end
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL reset_mid_grant got %b want 00", grant); end
      drv_flush = 1'b0;
      exp_q[0].delete();
      ram_en = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (obs_q.size() !== 0) begin errors++; $display("FAIL reset_mid_ready got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
      $display("txn reset during REQ abandoned");
   endtask

   task automatic test_timeout();
      bit   ok;
      obs_t o;
      exp_t e;
      int   terr_base;
      terr_base = terr_cycles;
      ram_en = 1'b0;
      @(posedge clk);
      cmd_q[0].push_back('{1'b0, 32'h34, 32'h0, 4'h0});
`ifdef MEM_TIMEOUT_EN
      wait_obs(1, 80, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL timeout_no_ready got none want ready"); end
      else begin
         o = obs_q.pop_front();
         e = exp_q[0].pop_front();
         checks++;
         if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_rdata got %h want deadbeef", o.rdata); end
         checks++;
         if (o.terr !== 1'b1) begin errors++; $display("FAIL timeout_err_flag got %b want 1", o.terr); end
         checks++;
         if (o.cyc - e.issue_cyc !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", o.cyc - e.issue_cyc, TIMEOUT + 1); end
         repeat (4) @(negedge clk);
         checks++;
         if (terr_cycles - terr_base !== 1) begin errors++; $display("FAIL timeout_err_width got %0d want 1", terr_cycles - terr_base); end
         $display("txn m0 timeout rdata=%h", o.rdata);
      end
      ram_en = 1'b1;
`else
      ok = 1'b0;
      repeat (100) @(negedge clk);
      checks++;
      if (obs_q.size() !== 0) begin errors++; $display("FAIL no_timeout_ready got %0d want 0", obs_q.size()); obs_q.delete(); end
      checks++;
      if (terr_cycles !== terr_base) begin errors++; $display("FAIL no_timeout_err got %0d want %0d", terr_cycles, terr_base); end
      drv_flush = 1'b1;
      repeat (2) @(negedge clk);
      apply_reset();
      drv_flush = 1'b0;
      exp_q[0].delete();
      ram_en = 1'b1;
      $display("txn m0 waited 100 cycles, no timeout ok=%0d", ok);
`endif
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_round_robin();
      test_write();
      test_reset_mid();
      test_timeout();
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q[0].size() + exp_q[1].size() + obs_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d leftover want 0", exp_q[0].size() + exp_q[1].size() + obs_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_watchdog got timeout want finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end
endmodule
